ps_tx_scheduler: RTL and testbench
==================================

Name: ps_tx_scheduler

Overview:
- Shares one parallel-to-serial converter (8-bit `valid`/`data_in` side, clocked on `cclk`) between NUM_REQ byte sources.
- Grants the converter in bounded bursts using round-robin arbitration.
- Frames each burst with a COM header byte, stuffs IDLE symbols during source stalls, and enforces a one-cycle invalid gap between bursts.
- Sits directly upstream of the serializer, in the `cclk` domain.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_W, 8, byte width; must match the serializer input.
- MAX_BURST, 4, maximum data bytes per grant (>=1).

Ports:
- cclk  in  1  core clock; all state updates on posedge.
- reset_L  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; level, held for the whole burst.
- req_valid  in  NUM_REQ  per-requester byte-valid, sampled only while granted.
- req_data  in  NUM_REQ*DATA_W  requester i data on bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot grant; combinational from state/owner.
- ser_valid  out  1  to serializer `valid`; registered.
- ser_data  out  DATA_W  to serializer `data_in`; registered.
- busy  out  1  high when state != IDLE.
- owner  out  clog2(NUM_REQ)  current or last granted index.

Behaviour:
- Reset (async, reset_L=0):
  - state=IDLE, ser_valid=0, ser_data=0, owner=0, cnt=0.
  - last_owner=NUM_REQ-1, so requester 0 wins first.
  - gnt=0, busy=0.
- States: IDLE, HDR, BURST, TAIL.
- IDLE:
  - If |req: winner = first set req scanning last_owner+1 upward with wrap.
  - owner<=winner, cnt<=0, ser_valid<=1, ser_data<=COM_SYM (8'hBC), state<=HDR.
  - Otherwise ser_valid<=0, ser_data<=0.
- HDR and BURST:
  - gnt[owner]=1; output currently shows COM (HDR) or the previous byte (BURST).
  - Each posedge, first matching case wins:
    - req[owner]=0: ser_valid<=0, ser_data<=0, last_owner<=owner, state<=IDLE. Early release; no byte taken.
    - req_valid[owner]=1: ser_valid<=1, ser_data<=req_data[owner], cnt<=cnt+1. If cnt+1==MAX_BURST then state<=TAIL, else BURST.
    - req_valid[owner]=0: ser_valid<=1, ser_data<=IDLE_SYM (8'h7C), cnt unchanged, state<=BURST. Stall; unbounded.
- TAIL:
  - gnt=0; output shows the last byte.
  - Next posedge: ser_valid<=0, ser_data<=0, last_owner<=owner, state<=IDLE.
- Latency: requester byte appears on ser_data one cycle after the cycle it is presented with gnt and req_valid high.
- Each burst on the output is COM, then 1..MAX_BURST data bytes (interleaved 7C on stalls), then at least one cycle with ser_valid=0.
- Requests arriving mid-burst wait; a new arbitration happens only in IDLE.
- cnt width: clog2(MAX_BURST+1); it never wraps.
- Reset asserted mid-burst aborts immediately to the reset values; no tail byte is emitted.

Optional Feature:
- Macro: PS_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; last_owner is ignored.
- Undefined: round-robin as specified above.
- Framing, stall handling and latency are identical either way.

Decomposition:
- Package ps_sched_pkg holds:
  - state encoding (IDLE=0, HDR=1, BURST=2, TAIL=3);
  - COM_SYM=8'hBC and IDLE_SYM=8'h7C;
  - the default DATA_W.
- Sub-module rr_arbiter: combinational winner select from req and last_owner, returning index and any-request.
  - The fixed-priority variant lives inside it under the macro.

Test Plan:
- Single requester: req[0]=1, bytes FF, DD, EE, CC each valid -> ser_data BC, FF, DD, EE, CC with ser_valid=1; then ser_valid=0 for one cycle; owner=0.
- Contention: req[0] and req[2] held high continuously, always valid -> bursts alternate owner 0, 2, 0, 2, each COM plus 4 bytes, with a one-cycle gap between bursts. With PS_SCHED_FIXED_PRIO_EN -> owner stays 0.
- Stall: req[1]=1; req_valid low for 2 cycles after the 2nd byte -> ser_data shows two 7C with ser_valid=1, and the burst still carries exactly 4 data bytes.
- Early release: req[3] drops after 2 bytes (AA, 55) -> ser shows BC, AA, 55, then ser_valid=0; next IDLE arbitration starts from index 0.
- Reset mid-burst: reset_L=0 during the 3rd byte -> ser_valid=0, ser_data=00, gnt=0, busy=0 at once. After release, req[1] wins first if req[0]=0.
- Idle: req=0 for 20 cycles -> ser_valid=0, ser_data=00, gnt=0 throughout.

Source files
------------

// File: rtl/ps_sched_pkg.sv
// Shared definitions for the parallel-to-serial transmit scheduler:
// FSM state encoding, framing symbols and the default byte width.
package ps_sched_pkg;

    localparam int DATA_W_DEF = 8;

    // Burst framing symbols seen by the serializer
    localparam logic [7:0] COM_SYM  = 8'hBC;
    localparam logic [7:0] IDLE_SYM = 8'h7C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_BURST = 2'd2,
        ST_TAIL  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational winner select for the transmit scheduler.
// Default: round-robin, scanning upward from last_owner+1 with wrap.
// With PS_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and last_owner is ignored.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

`ifdef PS_SCHED_FIXED_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner;

    // Lowest set index wins; scan downward so the last hit is the lowest
    always_comb begin
        winner  = '0;
        any_req = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) winner = IDX_W'(k);
        end
    end
`else
    // Nearest set index after last_owner wins; scan farthest offset first
    // so the final hit is the closest one
    always_comb begin
        int idx;
        idx     = 0;
        winner  = '0;
        any_req = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_owner) + k) % NUM_REQ;
            if (req[idx]) winner = IDX_W'(idx);
        end
    end
`endif

endmodule

// File: rtl/ps_tx_scheduler.sv
// Shares one parallel-to-serial converter between NUM_REQ byte sources.
// Each grant is a burst: COM header, 1..MAX_BURST data bytes (IDLE symbols
// stuffed while the source stalls), then at least one invalid cycle.
// Optional build macro: PS_SCHED_FIXED_PRIO_EN (fixed priority arbitration).
//
// Handshake: requester i owns the converter while gnt[i] is high; a byte is
// consumed on each posedge where gnt[i] and req_valid[i] are both high and
// appears on ser_data one cycle later. Dropping req[i] while granted ends the
// burst without taking a byte. The serializer side has no backpressure.
import ps_sched_pkg::*;

module ps_tx_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic                      cclk,
    input  logic                      reset_L,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      ser_valid,
    output logic [DATA_W-1:0]         ser_data,
    output logic                      busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output state_t                    dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [DATA_W-1:0] COM_W  = DATA_W'(COM_SYM);
    localparam logic [DATA_W-1:0] IDLE_W = DATA_W'(IDLE_SYM);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    last_owner;
    logic [IDX_W-1:0]    win_idx;
    logic                win_any;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                last_byte;
    logic [DATA_W-1:0]   src_data [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_src
        assign src_data[i] = req_data[i*DATA_W +: DATA_W];
    end

    assign cnt_inc   = cnt + CNT_W'(1);
    assign last_byte = (cnt_inc == CNT_W'(MAX_BURST));
    assign dbg_state = state;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .last_owner (last_owner),
        .winner     (win_idx),
        .any_req    (win_any)
    );

    // State register
    always_ff @(posedge cclk or negedge reset_L) begin
        if (!reset_L) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: arbitrate in IDLE, leave the burst on release or full count
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (win_any) state_nxt = ST_HDR;
            ST_HDR,
            ST_BURST: begin
                if (!req[owner])           state_nxt = ST_IDLE;
                else if (req_valid[owner]) state_nxt = last_byte ? ST_TAIL : ST_BURST;
                else                       state_nxt = ST_BURST;
            end
            ST_TAIL:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: grant only while the owner may send bytes
    always_comb begin
        gnt = '0;
        if (state == ST_HDR || state == ST_BURST) gnt[owner] = 1'b1;
        busy = (state != ST_IDLE);
    end

    // Registered serializer stream, owner tracking and burst byte count
    always_ff @(posedge cclk or negedge reset_L) begin
        if (!reset_L) begin
            ser_valid  <= 1'b0;
            ser_data   <= '0;
            owner      <= '0;
            cnt        <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        owner     <= win_idx;
                        cnt       <= '0;
                        ser_valid <= 1'b1;
                        ser_data  <= COM_W;
                    end else begin
                        ser_valid <= 1'b0;
                        ser_data  <= '0;
                    end
                end
                ST_HDR,
                ST_BURST: begin
                    if (!req[owner]) begin
                        ser_valid  <= 1'b0;
                        ser_data   <= '0;
                        last_owner <= owner;
                    end else if (req_valid[owner]) begin
                        ser_valid <= 1'b1;
                        ser_data  <= src_data[owner];
                        cnt       <= cnt_inc;
                    end else begin
                        ser_valid <= 1'b1;
                        ser_data  <= IDLE_W;
                    end
                end
                ST_TAIL: begin
                    ser_valid  <= 1'b0;
                    ser_data   <= '0;
                    last_owner <= owner;
                end
                default: begin
                    ser_valid <= 1'b0;
                    ser_data  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps_tx_scheduler.sv
// Directed bench for ps_tx_scheduler: a burst-level reference model checked
// every cycle, plus literal expected streams for each scenario.
module tb_ps_tx_scheduler;

    localparam int N  = 4;
    localparam int MB = 4;

    logic        cclk;
    logic        reset_L;
    logic [3:0]  req;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        ser_valid;
    logic [7:0]  ser_data;
    logic        busy;
    logic [1:0]  owner;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    logic [8:0] exp_q[$];

    ps_tx_scheduler dut (
        .cclk      (cclk),
        .reset_L   (reset_L),
        .req       (req),
        .req_valid (req_valid),
        .req_data  (req_data),
        .gnt       (gnt),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .busy      (busy),
        .owner     (owner),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    // ---------------- reference model ----------------
    // A burst is "open" from the header until the owner sends its last byte
    // or lets go; a closing burst spends one more cycle showing that byte.
    int         m_owner   = 0;
    int         m_last    = N - 1;
    int         m_taken   = 0;
    bit         m_open    = 1'b0;
    bit         m_closing = 1'b0;
    logic       m_sv      = 1'b0;
    logic [7:0] m_sd      = 8'h00;

    function automatic int pick(input logic [3:0] r, input int last);
`ifdef PS_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (r[k]) return k;
`else
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    always @(posedge cclk or negedge reset_L) begin
        if (!reset_L) begin
            m_owner <= 0; m_last <= N - 1; m_taken <= 0;
            m_open <= 1'b0; m_closing <= 1'b0; m_sv <= 1'b0; m_sd <= 8'h00;
        end else if (m_closing) begin
            m_sv <= 1'b0; m_sd <= 8'h00; m_last <= m_owner; m_closing <= 1'b0;
        end else if (m_open) begin
            if (!req[m_owner]) begin
                m_sv <= 1'b0; m_sd <= 8'h00; m_last <= m_owner; m_open <= 1'b0;
            end else if (req_valid[m_owner]) begin
                m_sv <= 1'b1; m_sd <= req_data[m_owner*8 +: 8];
                m_taken <= m_taken + 1;
                if (m_taken + 1 == MB) begin
                    m_open <= 1'b0; m_closing <= 1'b1;
                end
            end else begin
                m_sv <= 1'b1; m_sd <= 8'h7C;
            end
        end else if (req != 4'b0000) begin
            m_owner <= pick(req, m_last); m_taken <= 0; m_open <= 1'b1;
            m_sv <= 1'b1; m_sd <= 8'hBC;
        end else begin
            m_sv <= 1'b0; m_sd <= 8'h00;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge cclk) begin
        if (chk_en) begin
            logic [3:0] eg;
            eg = 4'b0000;
            if (m_open) eg[m_owner] = 1'b1;
            chk("cmp_ser_valid", 32'(ser_valid), 32'(m_sv));
            chk("cmp_ser_data",  32'(ser_data),  32'(m_sd));
            chk("cmp_gnt",       32'(gnt),       32'(eg));
            chk("cmp_busy",      32'(busy),      32'(m_open | m_closing));
            chk("cmp_owner",     32'(owner),     32'(m_owner));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic [3:0] r, input logic [3:0] v, input logic [31:0] d);
        req = r; req_valid = v; req_data = d;
        @(posedge cclk);
        #1;
    endtask

    // Drive one cycle, then check the stream against the next literal
    task automatic step(input string name, input logic [3:0] r, input logic [3:0] v,
                        input logic [31:0] d);
        logic [8:0] e;
        cyc(r, v, d);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        chk(name, 32'({ser_valid, ser_data}), 32'(e));
    endtask

    task automatic do_reset();
        req = '0; req_valid = '0; req_data = '0;
        reset_L = 1'b0;
        @(posedge cclk);
        #1;
        reset_L = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b;
        logic [7:0] eb;
        req = '0; req_valid = '0; req_data = '0;
        reset_L = 1'b1;
        #1 reset_L = 1'b0;
        #1;
        chk("rst_ser",   32'({ser_valid, ser_data}), 32'h000);
        chk("rst_gnt",   32'(gnt),   32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        @(posedge cclk);
        #1 reset_L = 1'b1;
        chk_en = 1'b1;

        // Single requester, full burst
        exp_q = '{9'h1BC, 9'h1FF, 9'h1DD, 9'h1EE, 9'h1CC, 9'h000};
        step("t1_com", 4'b0001, 4'b0001, 32'h0);
        chk("t1_owner", 32'(owner), 32'h0);
        chk("t1_gnt",   32'(gnt),   32'h1);
        step("t1_b0", 4'b0001, 4'b0001, 32'hFF);
        step("t1_b1", 4'b0001, 4'b0001, 32'hDD);
        step("t1_b2", 4'b0001, 4'b0001, 32'hEE);
        step("t1_b3", 4'b0001, 4'b0001, 32'hCC);
        chk("t1_tail_gnt",  32'(gnt),  32'h0);
        chk("t1_tail_busy", 32'(busy), 32'h1);
        step("t1_gap", 4'b0000, 4'b0000, 32'h0);

        // Contention between requesters 0 and 2
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            cyc(4'b0101, 4'b1111, {8'h00, 8'(8'h20 + c), 8'h00, 8'(8'h10 + c)});
            b = (c - 1) / 6;
`ifdef PS_SCHED_FIXED_PRIO_EN
            eb = 8'h10;
`else
            eb = (b % 2 == 0) ? 8'h10 : 8'h20;
`endif
            if (c % 6 == 1) begin
                chk("t2_com",   32'({ser_valid, ser_data}), 32'h1BC);
                chk("t2_owner", 32'(owner), (eb == 8'h10) ? 32'h0 : 32'h2);
            end else if (c % 6 == 0) begin
                chk("t2_gap", 32'({ser_valid, ser_data}), 32'h000);
            end else begin
                chk("t2_byte", 32'({ser_valid, ser_data}), 32'({1'b1, 8'(eb + c)}));
            end
        end
        cyc(4'b0000, 4'b0000, 32'h0);
        cyc(4'b0000, 4'b0000, 32'h0);

        // Stall on requester 1
        do_reset();
        exp_q = '{9'h1BC, 9'h1A1, 9'h1A2, 9'h17C, 9'h17C, 9'h1A3, 9'h1A4, 9'h000};
        step("t3_com",  4'b0010, 4'b0000, 32'h0);
        step("t3_b0",   4'b0010, 4'b0010, 32'h0000A100);
        step("t3_b1",   4'b0010, 4'b0010, 32'h0000A200);
        step("t3_st0",  4'b0010, 4'b0000, 32'h0);
        step("t3_st1",  4'b0010, 4'b0000, 32'h0);
        step("t3_b2",   4'b0010, 4'b0010, 32'h0000A300);
        step("t3_b3",   4'b0010, 4'b0010, 32'h0000A400);
        step("t3_gap",  4'b0000, 4'b0000, 32'h0);
        chk("t3_busy", 32'(busy), 32'h0);

        // Early release by requester 3, then arbitration restarts at 0
        exp_q = '{9'h1BC, 9'h1AA, 9'h155, 9'h000, 9'h1BC, 9'h000};
        step("t4_com",  4'b1000, 4'b0000, 32'h0);
        chk("t4_owner3", 32'(owner), 32'h3);
        step("t4_b0",   4'b1000, 4'b1000, 32'hAA000000);
        step("t4_b1",   4'b1000, 4'b1000, 32'h55000000);
        step("t4_rel",  4'b0000, 4'b0000, 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);
        step("t4_com2", 4'b1111, 4'b0000, 32'h0);
        chk("t4_owner0", 32'(owner), 32'h0);
        step("t4_rel2", 4'b0000, 4'b0000, 32'h0);

        // Reset asserted during the third byte
        exp_q = '{9'h1BC, 9'h111, 9'h122};
        step("t5_com", 4'b0001, 4'b0000, 32'h0);
        step("t5_b0",  4'b0001, 4'b0001, 32'h11);
        step("t5_b1",  4'b0001, 4'b0001, 32'h22);
        req = 4'b0001; req_valid = 4'b0001; req_data = 32'h33;
        reset_L = 1'b0;
        #1;
        chk("t5_rst_ser",   32'({ser_valid, ser_data}), 32'h000);
        chk("t5_rst_gnt",   32'(gnt),   32'h0);
        chk("t5_rst_busy",  32'(busy),  32'h0);
        chk("t5_rst_owner", 32'(owner), 32'h0);
        #2 reset_L = 1'b1;
        exp_q = '{9'h1BC, 9'h000};
        step("t5_com1", 4'b0010, 4'b0000, 32'h0);
        chk("t5_owner1", 32'(owner), 32'h1);
        step("t5_rel",  4'b0000, 4'b0000, 32'h0);

        // Long idle
        for (int c = 0; c < 20; c++) begin
            cyc(4'b0000, 4'b0000, 32'h0);
            chk("t6_ser", 32'({ser_valid, ser_data}), 32'h000);
            chk("t6_gnt", 32'(gnt), 32'h0);
        end

        @(negedge cclk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
